// File: rtl/hough_pkg.sv
// hough_pkg: image geometry constants and frame reader state encoding shared by the Hough pipeline.
package hough_pkg;

    localparam int WIDTH = 720;
    localparam int HEIGHT = 540;
    localparam int IMAGE_SIZE = WIDTH * HEIGHT;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } reader_state_t;

endpackage

// File: rtl/pixel_skid_buffer.sv
// pixel_skid_buffer: two-entry in-order buffer absorbing the BRAM read latency under backpressure.
module pixel_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/bram_frame_reader.sv
// bram_frame_reader: streams a BRAM-held frame in raster order with (x, y) tags under downstream backpressure.
module bram_frame_reader #(
    parameter int BRAM_DATA_WIDTH = 8,
    parameter int WIDTH = hough_pkg::WIDTH,
    parameter int HEIGHT = hough_pkg::HEIGHT,
    parameter int IMAGE_SIZE = hough_pkg::IMAGE_SIZE,
    localparam int AW = $clog2(IMAGE_SIZE),
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    output logic [AW-1:0]              rd_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] rd_data,
    input  logic                       out_full,
    output logic                       out_wr_en,
    output logic [BRAM_DATA_WIDTH-1:0] out_dout,
    output logic [XW-1:0]              out_x,
    output logic [YW-1:0]              out_y,
    output logic                       busy,
    output logic                       done
);

    import hough_pkg::*;

    reader_state_t state, next_state;
    logic          inflight;
    logic          issue;
    logic          drained;
    logic [1:0]    count;
    logic [2:0]    credit;

    pixel_skid_buffer #(.W(BRAM_DATA_WIDTH)) u_buf (
        .clock(clock),
        .reset(reset),
        .push (inflight),
        .pop  (out_wr_en),
        .din  (rd_data),
        .head (out_dout),
        .count(count)
    );

    // A slot freed by this cycle's pop can be reused by this cycle's issue.
    assign out_wr_en = (count != 2'd0) && !out_full;
    assign credit    = {1'b0, count} + {2'b0, inflight};
    assign issue     = (state == RUN) && (credit < 3'd2 + {2'b0, out_wr_en});
    assign drained   = !inflight && ((count == 2'd0) || (count == 2'd1 && out_wr_en));
    assign busy      = state != IDLE;

    always_comb begin
        next_state = state;
        if (state == IDLE && start)
            next_state = RUN;
        else if (state == RUN && issue && rd_addr == AW'(IMAGE_SIZE - 1))
            next_state = DRAIN;
        else if (state == DRAIN && drained)
            next_state = IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_addr  <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
            out_x    <= '0;
            out_y    <= '0;
        end else begin
            inflight <= issue;
            done     <= (state == DRAIN) && (next_state == IDLE);
            if (state == IDLE && start) begin
                rd_addr <= '0;
                out_x   <= '0;
                out_y   <= '0;
            end else begin
                if (issue)
                    rd_addr <= rd_addr + AW'(1);
                if (out_wr_en) begin
                    out_x <= (out_x == XW'(WIDTH - 1)) ? '0 : out_x + XW'(1);
                    if (out_x == XW'(WIDTH - 1))
                        out_y <= (out_y == YW'(HEIGHT - 1)) ? '0 : out_y + YW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_frame_reader.sv
// tb_bram_frame_reader: scoreboard bench driving a 4x3 frame through the reader under varied backpressure.
module tb_bram_frame_reader;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = 12;

    typedef struct packed {
        logic [7:0] v;
        logic [1:0] x;
        logic [1:0] y;
    } pix_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       out_full = 1'b0;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] out_dout;
    logic       out_wr_en;
    logic [1:0] out_x;
    logic [1:0] out_y;
    logic       busy;
    logic       done;

    logic [7:0] mem [N];
    pix_t       sb [$];
    pix_t       exp_p;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         wr_total = 0;
    int         frame_base = 0;
    int         first_wr_cyc = -1;
    int         last_wr_cyc = -1;
    int         done_total = 0;
    int         c0;
    int         d0;
    bit         rnd_en = 1'b0;

    bram_frame_reader #(
        .BRAM_DATA_WIDTH(8),
        .WIDTH(W),
        .HEIGHT(H),
        .IMAGE_SIZE(N)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_full (out_full),
        .out_wr_en(out_wr_en),
        .out_dout (out_dout),
        .out_x    (out_x),
        .out_y    (out_y),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    initial for (int i = 0; i < N; i++) mem[i] = 8'(i + 16);

    always @(posedge clock) begin
        rd_data <= (int'(rd_addr) < N) ? mem[rd_addr] : 8'd0;
        cyc     <= cyc + 1;
    end

    always @(negedge clock) begin
        if (reset) begin
            if (busy) begin
                checks++;
                if (int'(rd_addr) - (wr_total - frame_base) > 2) begin
                    errors++;
                    $display("FAIL occupancy issued=%0d written=%0d limit=2", rd_addr, wr_total - frame_base);
                end
            end
            if (out_full) begin
                checks++;
                if (out_wr_en) begin
                    errors++;
                    $display("FAIL write_while_full got=1 exp=0");
                end
            end
            if (out_wr_en) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got v=%0d x=%0d y=%0d exp none", out_dout, out_x, out_y);
                end else begin
                    exp_p = sb.pop_front();
                    if (exp_p != {out_dout, out_x, out_y}) begin
                        errors++;
                        $display("FAIL pixel got v=%0d x=%0d y=%0d exp v=%0d x=%0d y=%0d",
                                 out_dout, out_x, out_y, exp_p.v, exp_p.x, exp_p.y);
                    end
                end
                if (wr_total == frame_base) first_wr_cyc = cyc;
                wr_total++;
                last_wr_cyc = cyc;
            end
            if (done) begin
                checks++;
                done_total++;
                if (last_wr_cyc != cyc - 1 || busy) begin
                    errors++;
                    $display("FAIL done_timing got last_wr=%0d busy=%0d exp last_wr=%0d busy=0", last_wr_cyc, busy, cyc - 1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (rnd_en) out_full = 1'($urandom_range(0, 1));
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic begin_frame(output int c);
        start = 1'b1;
        for (int i = 0; i < N; i++) sb.push_back(pix_t'{8'(i + 16), 2'(i % W), 2'(i / W)});
        frame_base = wr_total;
        c = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 0, 1);
    endtask

    task automatic wait_writes(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (wr_total - frame_base >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check("writes_timeout", wr_total - frame_base, n);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_addr"}, int'(rd_addr), 0);
        check({tag, "_wr_en"}, int'(out_wr_en), 0);
        check({tag, "_dout"}, int'(out_dout), 0);
        check({tag, "_x"}, int'(out_x), 0);
        check({tag, "_y"}, int'(out_y), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b1;
        check_zero("por");

        d0 = done_total;
        begin_frame(c0);
        wait_done();
        check("first_write_cycle", first_wr_cyc, c0 + 3);
        check("burst_span", last_wr_cyc - first_wr_cyc, N - 1);
        check("frame1_drained", sb.size(), 0);
        repeat (2) step();
        check("done_pulses", done_total - d0, 1);

        out_full = 1'b1;
        begin_frame(c0);
        repeat (8) step();
        check("stall_rd_addr", int'(rd_addr), 2);
        check("stall_writes", wr_total - frame_base, 0);
        check("stall_busy", int'(busy), 1);
        out_full = 1'b0;
        wait_done();
        check("stall_drained", sb.size(), 0);

        rnd_en = 1'b1;
        begin_frame(c0);
        wait_done();
        check("random_drained", sb.size(), 0);
        check("random_count", wr_total - frame_base, N);

        begin_frame(c0);
        wait_writes(5);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        check("busy_start_drained", sb.size(), 0);
        check("busy_start_count", wr_total - frame_base, N);
        begin_frame(c0);
        wait_done();
        check("done_start_drained", sb.size(), 0);
        check("done_start_count", wr_total - frame_base, N);
        rnd_en = 1'b0;
        out_full = 1'b0;

        begin_frame(c0);
        wait_writes(6);
        reset = 1'b0;
        sb.delete();
        step();
        check_zero("midreset");
        reset = 1'b1;
        step();
        begin_frame(c0);
        wait_done();
        check("restart_first_cycle", first_wr_cyc, c0 + 3);
        check("restart_drained", sb.size(), 0);

        repeat (3) step();
        check("final_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
